// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions: widths, reset vector, instruction word type,
// base opcodes and the fetch-stage state encoding.
package riscv_pkg;

  localparam int              XLEN     = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef logic [31:0] instr_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {BOOT, RUN, HOLD} fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding register; load captures, drain empties, flush wins over both.
// Zero latency out of the register; the owner decides when to load (no overflow protection here).
module fetch_skid_buf #(
  parameter int XLEN = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_i,
  input  logic                     drain_i,
  input  logic                     flush_i,
  input  riscv_pkg::instr_t        instr_i,
  input  logic [XLEN-1:0]          pc_i,
  output logic                     valid_o,
  output riscv_pkg::instr_t        instr_o,
  output logic [XLEN-1:0]          pc_o
);
  import riscv_pkg::*;

  logic            valid_q;
  instr_t          instr_q;
  logic [XLEN-1:0] pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC register, 1-cycle sync imem, valid/ready to decode with a 1-entry skid; issue->valid is 1 cycle,
// redirect has priority and kills in-flight/skid data. FETCH_PERF_EN adds transfer/stall counters.
module instr_fetch_stage #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_en_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [31:0]     imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt_o,
  output logic [31:0]     perf_stall_cnt_o
`endif
);
  import riscv_pkg::*;

  fetch_state_e    state_q, state_d;
  logic            inflight_q;
  logic [XLEN-1:0] pc_q, inflight_pc_q;
  logic            issue, skid_load, skid_drain, skid_valid, has_data;
  instr_t          skid_instr;
  logic [XLEN-1:0] skid_pc, fetch_addr;

  assign fetch_addr = redirect_i ? {redirect_pc_i[XLEN-1:2], 2'b00} : pc_q;

  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    case (state_q)
      BOOT: begin
        issue   = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (redirect_i || ready_i || !inflight_q) begin
          issue = 1'b1;
        end else begin
          skid_load = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (redirect_i || ready_i) begin
          issue      = 1'b1;
          skid_drain = 1'b1;
          state_d    = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
    // BOOT is also the reset state; keep the memory quiet until reset is released.
    if (!rst_n) issue = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (issue) begin
        pc_q          <= fetch_addr + XLEN'(4);
        inflight_pc_q <= fetch_addr;
      end
    end
  end

  fetch_skid_buf #(.XLEN(XLEN)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .flush_i (redirect_i),
    .instr_i (imem_rdata_i),
    .pc_i    (inflight_pc_q),
    .valid_o (skid_valid),
    .instr_o (skid_instr),
    .pc_o    (skid_pc)
  );

  assign imem_en_o   = issue;
  assign imem_addr_o = fetch_addr;

  // Data outputs read as zero whenever nothing is held, so reset and boot present a clean bus.
  assign has_data   = skid_valid | inflight_q;
  assign valid_o    = has_data & ~redirect_i;
  assign instr_o    = skid_valid ? skid_instr : (inflight_q ? imem_rdata_i : '0);
  assign pc_o       = skid_valid ? skid_pc : (inflight_q ? inflight_pc_q : '0);
  assign pc_plus4_o = has_data ? pc_o + XLEN'(4) : '0;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (valid_o && ready_i)  fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (valid_o && !ready_i) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt_o = fetch_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: a main instance (reset vector 0) driven through stall,
// redirect and mid-stall reset, plus a free-running instance whose reset vector sits at the top of memory.
module tb_instr_fetch_stage;

  localparam logic [31:0] TAG = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ready_i = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;

  logic        imem_en, valid, w_imem_en, w_valid;
  logic [31:0] imem_addr, instr, pc, pc4;
  logic [31:0] w_imem_addr, w_instr, w_pc, w_pc4;
  logic [31:0] imem_rdata = '0;
  logic [31:0] w_imem_rdata = '0;

  int n_vec = 0;
  int n_err = 0;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch, perf_stall, w_perf_fetch, w_perf_stall;
  int          exp_fetch = 0;
  int          exp_stall = 0;
`endif

  always #5 clk = ~clk;

  instr_fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_en_o     (imem_en),
    .imem_addr_o   (imem_addr),
    .imem_rdata_i  (imem_rdata),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .valid_o       (valid),
    .ready_i       (ready_i),
    .instr_o       (instr),
    .pc_o          (pc),
    .pc_plus4_o    (pc4)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt_o (perf_fetch),
    .perf_stall_cnt_o (perf_stall)
`endif
  );

  instr_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_en_o     (w_imem_en),
    .imem_addr_o   (w_imem_addr),
    .imem_rdata_i  (w_imem_rdata),
    .redirect_i    (1'b0),
    .redirect_pc_i (32'h0),
    .valid_o       (w_valid),
    .ready_i       (1'b1),
    .instr_o       (w_instr),
    .pc_o          (w_pc),
    .pc_plus4_o    (w_pc4)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt_o (w_perf_fetch),
    .perf_stall_cnt_o (w_perf_stall)
`endif
  );

  // Instruction memories: each word is its own address xor TAG, returned one cycle after the strobe.
  always @(posedge clk) begin
    if (imem_en)   imem_rdata   <= imem_addr ^ TAG;
    if (w_imem_en) w_imem_rdata <= w_imem_addr ^ TAG;
  end

`ifdef FETCH_PERF_EN
  always @(negedge clk) begin
    if (rst_n && valid && ready_i)  exp_fetch++;
    if (rst_n && valid && !ready_i) exp_stall++;
  end
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One cycle: inputs change 2 ns after the edge, outputs are checked 4 ns after it.
  task automatic cyc(input logic rdy, input logic rdr, input logic [31:0] rpc);
    @(posedge clk);
    #2;
    ready_i       = rdy;
    redirect_i    = rdr;
    redirect_pc_i = rpc;
    #2;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] exp_pc);
    chk({tag, " valid"}, {31'b0, valid}, 32'd1);
    chk({tag, " pc"},    pc,            exp_pc);
    chk({tag, " instr"}, instr,         exp_pc ^ TAG);
    chk({tag, " pc4"},   pc4,           exp_pc + 32'd4);
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst valid", {31'b0, valid}, 32'd0);
    chk("rst en",    {31'b0, imem_en}, 32'd0);
    chk("rst instr", instr, 32'd0);
    chk("rst pc",    pc, 32'd0);
    chk("rst pc4",   pc4, 32'd0);

    // Test 1: boot and streaming
    @(posedge clk);
    #2 rst_n = 1'b1;
    #2;
    chk("boot en",     {31'b0, imem_en}, 32'd1);
    chk("boot addr",   imem_addr, 32'h0);
    chk("boot valid",  {31'b0, valid}, 32'd0);
    chk("wboot addr",  w_imem_addr, 32'hFFFF_FFF8);
    cyc(1'b1, 1'b0, 32'h0);
    chk_out("c1", 32'h0);
    chk("c1 addr", imem_addr, 32'h4);
    chk("w c1 pc",  w_pc,  32'hFFFF_FFF8);
    chk("w c1 pc4", w_pc4, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 32'h0);
    chk_out("c2", 32'h4);
    chk("w c2 pc",  w_pc,  32'hFFFF_FFFC);
    chk("w c2 pc4", w_pc4, 32'h0);

    // Test 2: three stall cycles on pc 0x8
    cyc(1'b0, 1'b0, 32'h0);
    chk_out("c3", 32'h8);
    chk("c3 en", {31'b0, imem_en}, 32'd0);
    chk("w c3 pc",    w_pc,    32'h0);
    chk("w c3 instr", w_instr, TAG);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 32'h0);
      chk_out("hold", 32'h8);
      chk("hold en", {31'b0, imem_en}, 32'd0);
    end
    cyc(1'b1, 1'b0, 32'h0);
    chk_out("drain", 32'h8);
    chk("drain en",   {31'b0, imem_en}, 32'd1);
    chk("drain addr", imem_addr, 32'hC);
    cyc(1'b1, 1'b0, 32'h0);
    chk_out("c7", 32'hC);
    cyc(1'b1, 1'b0, 32'h0);
    chk_out("c8", 32'h10);
`ifdef FETCH_PERF_EN
    chk("perf fetch", perf_fetch, 32'(exp_fetch));
    chk("perf stall", perf_stall, 32'(exp_stall));
`endif

    // Test 3: redirect to 0x100 while pc 0x20 is presented
    for (int a = 32'h14; a <= 32'h1C; a += 4) begin
      cyc(1'b1, 1'b0, 32'h0);
      chk_out("seq", 32'(a));
    end
    cyc(1'b1, 1'b1, 32'h100);
    chk("redir pc",    pc, 32'h20);
    chk("redir valid", {31'b0, valid}, 32'd0);
    chk("redir en",    {31'b0, imem_en}, 32'd1);
    chk("redir addr",  imem_addr, 32'h100);
    cyc(1'b1, 1'b0, 32'h0);
    chk_out("tgt", 32'h100);
    chk("tgt addr", imem_addr, 32'h104);

    // Test 4: redirect to unaligned 0x43 while the skid is full and decode stalls
    cyc(1'b0, 1'b0, 32'h0);
    chk_out("pre hold", 32'h104);
    cyc(1'b0, 1'b1, 32'h43);
    chk("hredir valid", {31'b0, valid}, 32'd0);
    chk("hredir addr",  imem_addr, 32'h40);
    chk("hredir en",    {31'b0, imem_en}, 32'd1);
    cyc(1'b0, 1'b0, 32'h0);
    chk_out("h tgt", 32'h40);
    chk("h tgt en", {31'b0, imem_en}, 32'd0);
    cyc(1'b1, 1'b0, 32'h0);
    chk_out("h drain", 32'h40);
    chk("h drain addr", imem_addr, 32'h44);
    cyc(1'b0, 1'b0, 32'h0);
    chk_out("c18", 32'h44);

    // Test 6: reset pulse in the middle of a stall
    cyc(1'b0, 1'b0, 32'h0);
    chk_out("c19", 32'h44);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst valid", {31'b0, valid}, 32'd0);
    chk("mrst en",    {31'b0, imem_en}, 32'd0);
    chk("mrst instr", instr, 32'd0);
    chk("mrst pc",    pc, 32'd0);
    chk("mrst pc4",   pc4, 32'd0);
    @(posedge clk);
    #2;
    rst_n   = 1'b1;
    ready_i = 1'b1;
    #2;
    chk("reboot en",   {31'b0, imem_en}, 32'd1);
    chk("reboot addr", imem_addr, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    chk_out("reboot", 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
